acc_bank: RTL

//  Parametrised accumulator bank for the COA CPU datapath: NUM_ACC accumulators of WIDTH bits.

---
 rtl/acc_pkg.sv | 35 +++
 rtl/acc_addsub.sv | 32 +++
 rtl/acc_bank.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator bank: control-word bit positions,
// shift FSM states and the packed flag record.
package acc_pkg;

  localparam int CON_LD  = 9;
  localparam int CON_ADD = 10;
  localparam int CON_SUB = 11;
  localparam int CON_CLR = 12;
  localparam int CON_SHL = 13;
  localparam int CON_SHR = 14;
  localparam int CON_SAT = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  function automatic flags_t make_flags(input logic zero, input logic neg,
                                        input logic carry, input logic ovf);
    flags_t f;
    f.z = zero;
    f.n = neg;
    f.c = carry;
    f.v = ovf;
    return f;
  endfunction

endpackage

// File: rtl/acc_addsub.sv
// Combinational add/subtract with carry (borrow on subtract), signed
// overflow detection and optional clamping to the signed range.
module acc_addsub #(
  parameter int WIDTH  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] raw;

  // The extra top bit of a (WIDTH+1)-bit difference is set exactly when a borrow occurs.
  always_comb begin
    ext      = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    raw      = ext[WIDTH-1:0];
    carry    = ext[WIDTH];
    overflow = sub ? ((a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]))
                   : ((a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]));
    result   = raw;
    if (SAT_EN && sat && overflow) begin
      result = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/acc_bank.sv
// Accumulator bank between ALU output and ALU A-input: in-place load, add,
// subtract, clear and bit-serial shifts, with registered Z/N/C/V flags.
module acc_bank
  import acc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_ACC = 4,
  parameter int CON_W   = 32,
  parameter bit SAT_EN  = 1'b1,
  localparam int SW     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1,
  localparam int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CON_W-1:0] con,
  input  logic [SW-1:0]    acc_sel,
  input  logic [WIDTH-1:0] alu_in,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] acc_out,
  output logic             busy,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  logic [WIDTH-1:0] acc [NUM_ACC];

  state_t           state, state_d;
  logic [SHW-1:0]   count, count_d;
  logic [SW-1:0]    shift_sel, shift_sel_d;
  logic             shift_left, shift_left_d;
  flags_t           flags, flags_d;

  logic             wr_en;
  logic [SW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  logic             sel_valid;
  logic [WIDTH-1:0] shift_cur;
  logic [WIDTH-1:0] shifted;
  logic             bit_out;

  logic [WIDTH-1:0] as_result;
  logic             as_carry;
  logic             as_overflow;

  logic             cmd_ld, cmd_add, cmd_sub, cmd_clr, cmd_shl, cmd_shr, cmd_sat;
  logic             unused_con_bits;

  assign cmd_ld  = con[CON_LD];
  assign cmd_add = con[CON_ADD];
  assign cmd_sub = con[CON_SUB];
  assign cmd_clr = con[CON_CLR];
  assign cmd_shl = con[CON_SHL];
  assign cmd_shr = con[CON_SHR];
  assign cmd_sat = con[CON_SAT];
  assign unused_con_bits = ^{con[CON_W-1:CON_SAT+1], con[CON_LD-1:0]};

  assign sel_valid = ({1'b0, acc_sel} < (SW+1)'(NUM_ACC));

  // Out-of-range selects fall through to zero because no entry matches.
  always_comb begin
    acc_out   = '0;
    shift_cur = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (acc_sel == SW'(i)) begin
        acc_out = acc[i];
      end
      if (shift_sel == SW'(i)) begin
        shift_cur = acc[i];
      end
    end
  end

  assign shifted = shift_left ? {shift_cur[WIDTH-2:0], 1'b0}
                              : {shift_cur[WIDTH-1], shift_cur[WIDTH-1:1]};
  assign bit_out = shift_left ? shift_cur[WIDTH-1] : shift_cur[0];

  acc_addsub #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_addsub (
    .a        (acc_out),
    .b        (alu_in),
    .sub      (~cmd_add),
    .sat      (cmd_sat),
    .result   (as_result),
    .carry    (as_carry),
    .overflow (as_overflow)
  );

  // Command decode and shift sequencing; everything holds unless a command acts.
  always_comb begin
    state_d      = state;
    count_d      = count;
    shift_sel_d  = shift_sel;
    shift_left_d = shift_left;
    flags_d      = flags;
    wr_en        = 1'b0;
    wr_idx       = acc_sel;
    wr_data      = '0;

    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          if (cmd_clr) begin
            wr_en   = 1'b1;
            flags_d = make_flags(1'b1, 1'b0, 1'b0, 1'b0);
          end else if (cmd_ld) begin
            wr_en   = 1'b1;
            wr_data = alu_in;
            flags_d = make_flags(alu_in == '0, alu_in[WIDTH-1], 1'b0, 1'b0);
          end else if (cmd_add || cmd_sub) begin
            wr_en   = 1'b1;
            wr_data = as_result;
            flags_d = make_flags(as_result == '0, as_result[WIDTH-1], as_carry, as_overflow);
          end else if ((cmd_shl || cmd_shr) && (shamt != '0)) begin
            state_d      = SHIFT;
            count_d      = shamt;
            shift_sel_d  = acc_sel;
            shift_left_d = cmd_shl;
          end
        end
      end

      SHIFT: begin
        if (cmd_clr) begin
          wr_en   = sel_valid;
          state_d = IDLE;
          count_d = '0;
          flags_d = make_flags(1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
          // Flags track each step so they describe the final value on exit.
          wr_en   = 1'b1;
          wr_idx  = shift_sel;
          wr_data = shifted;
          count_d = count - SHW'(1);
          flags_d = make_flags(shifted == '0, shifted[WIDTH-1], bit_out, 1'b0);
          if (count == SHW'(1)) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      shift_sel  <= '0;
      shift_left <= 1'b0;
      flags      <= '0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      shift_sel  <= shift_sel_d;
      shift_left <= shift_left_d;
      flags      <= flags_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (wr_idx == SW'(i)) begin
          acc[i] <= wr_data;
        end
      end
    end
  end

  assign busy   = (state == SHIFT);
  assign flag_z = flags.z;
  assign flag_n = flags.n;
  assign flag_c = flags.c;
  assign flag_v = flags.v;

endmodule
